csr_access_ctrl: RTL
====================

Name: csr_access_ctrl

Overview:
- Sequences all accesses to the single-port, synchronous-read CSR storage array.
- Decoded CSR instructions are turned into read / modify / write sequences (CSRRW/RS/RC and immediate forms).
- Arbitrates the array between the pipeline CSR request port and the trap unit; the trap unit has fixed priority.
- Sits between the decode stage (csr_op_ctr, csr_imm_en, csr_read_en, csr_wr_en) and the CSR array.

Parameters:
XLEN, 32, CSR data width
ADR_W, 12, CSR address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  pipeline CSR request valid
req_ready  out  1  request accepted this cycle when valid&ready
req_csr_adr  in  ADR_W  target CSR address
req_op_ctr  in  2  0=write, 1=set, 2=clear, 3=none
req_imm_en  in  1  source is zero-extended zimm, not rs1_data
req_rs1_data  in  XLEN  register source operand
req_zimm  in  5  immediate source (rs1 field)
req_read_en  in  1  old CSR value returned to rd
req_wr_en  in  1  CSR is written
req_rd_adr  in  5  destination register
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  old CSR value (0 if no read)
rsp_rd_adr  out  5  latched req_rd_adr
rsp_rd_we  out  1  register write enable for rsp_rdata
trap_valid  in  1  trap unit write request
trap_ready  out  1  trap request accepted
trap_adr  in  ADR_W  trap write address
trap_wdata  in  XLEN  trap write data
ram_en  out  1  array access enable
ram_we  out  1  array write enable
ram_adr  out  ADR_W  array address
ram_wdata  out  XLEN  array write data
ram_rdata  in  XLEN  array read data, valid one cycle after read issue
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst_n synchronous, active-low.
- Reset values: state=IDLE; all outputs 0 except req_ready/trap_ready, which follow the IDLE rules below.
- Reset mid-operation: on the next clk edge the controller returns to IDLE and drops the transaction. No rsp_valid is issued and no write is issued.
- States: IDLE, READ, WAIT, WRITE, RESP, TRAP_WR.
- Ready rules (combinational from state and inputs):
  - trap_ready = (state==IDLE).
  - req_ready = (state==IDLE) & ~trap_valid.
  - Simultaneous trap_valid and req_valid in IDLE: the trap wins and the request waits; req inputs must hold until accepted.
- Trap accept: IDLE -> TRAP_WR. In TRAP_WR: ram_en=1, ram_we=1, ram_adr/ram_wdata = latched trap_adr/trap_wdata. Then -> IDLE.
- Request accept in IDLE latches: adr, op, rd_adr, read_en, and eff_wr = req_wr_en & (op!=3).
  - src = req_imm_en ? {27'b0,req_zimm} : req_rs1_data.
- Next state after request accept:
  - READ if read_en | (eff_wr & op!=0).
  - Else WRITE if eff_wr.
  - Else RESP.
- READ: ram_en=1, ram_we=0, ram_adr=latched adr. -> WAIT.
- WAIT: capture old=ram_rdata.
  - new = op0: src; op1: old|src; op2: old&~src.
  - -> WRITE if eff_wr, else RESP.
- WRITE: ram_en=1, ram_we=1, ram_wdata=new (src if READ was skipped). -> RESP.
- RESP: rsp_valid=1 for exactly one cycle.
  - rsp_rdata = read_en ? old : 0.
  - rsp_rd_we = read_en.
  - rsp_rd_adr = latched rd_adr.
  - -> IDLE.
- ram_en=0 in IDLE and RESP; ram_we=0 whenever ram_en=0.
- Latency from accept cycle T to rsp_valid:
  - Read+write: T+4.
  - Read-only: T+3.
  - Write-only (op0, no read): T+2.
  - Neither read nor write: T+1.
- Back-to-back: a new accept is possible in the IDLE cycle directly after RESP, i.e. one transaction per latency+1 cycles at best.
- Trap write throughput: one per 2 cycles.
- Operand width: zimm always zero-extended; no sign extension anywhere.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-READ -> state IDLE, rsp_valid=0, ram_en=0, busy=0; no write observed.
- CSRRW write-only: op0, read_en=0, wr_en=1, adr=0x305, rs1=0x8000_0100 -> single write of 0x8000_0100 to 0x305 at T+1; rsp_valid at T+2 with rd_we=0.
- CSRRS: array[0x300]=0x0000_0008, op1, rs1=0x0000_0080, read_en=1 -> read at T+1; write 0x0000_0088 at T+3; rsp_rdata=0x0000_0008, rd_we=1 at T+4.
- CSRRCI: array[0x300]=0xFF, op2, imm_en=1, zimm=5'h0F, wr_en=1, read_en=1 -> write 0xF0; rsp_rdata=0xFF at T+4.
- Read-only CSRRS with rs1=x0 (wr_en=0): array[0xC00]=0x1234 -> no ram_we pulse; rsp_rdata=0x1234 at T+3.
- Arbitration: trap_valid and req_valid both high in IDLE, trap_adr=0x341, trap_wdata=0x40 -> trap written first (trap_ready=1, req_ready=0). The request is accepted 2 cycles later and completes normally.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl
// Sequences every access to the single-port, synchronous-read CSR array.
// Decoded CSR instructions (CSRRW/RS/RC and their immediate forms) become
// read / modify / write sequences. The trap unit shares the array and has
// fixed priority over the pipeline request port.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_*               pipeline CSR request (valid/ready handshake)
//   rsp_*               one-cycle completion pulse with old CSR value for rd
//   trap_*              trap unit write request (valid/ready handshake)
//   ram_*               CSR array port; ram_rdata is valid one cycle after a read
//   busy                controller is not idle
module csr_access_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ADR_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADR_W-1:0] req_csr_adr,
  input  logic [1:0]       req_op_ctr,
  input  logic             req_imm_en,
  input  logic [XLEN-1:0]  req_rs1_data,
  input  logic [4:0]       req_zimm,
  input  logic             req_read_en,
  input  logic             req_wr_en,
  input  logic [4:0]       req_rd_adr,
  output logic             rsp_valid,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic [4:0]       rsp_rd_adr,
  output logic             rsp_rd_we,
  input  logic             trap_valid,
  output logic             trap_ready,
  input  logic [ADR_W-1:0] trap_adr,
  input  logic [XLEN-1:0]  trap_wdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [ADR_W-1:0] ram_adr,
  output logic [XLEN-1:0]  ram_wdata,
  input  logic [XLEN-1:0]  ram_rdata,
  output logic             busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRead   = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StWrite  = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;
  localparam logic [2:0] StTrapWr = 3'd5;

  localparam logic [1:0] OpWrite = 2'd0;
  localparam logic [1:0] OpSet   = 2'd1;
  localparam logic [1:0] OpClear = 2'd2;
  localparam logic [1:0] OpNone  = 2'd3;

  logic [2:0]       r_state;
  logic [2:0]       w_state_d;
  // r_adr / r_src double as the trap write address / data while in StTrapWr.
  logic [ADR_W-1:0] r_adr;
  logic [XLEN-1:0]  r_src;
  logic [XLEN-1:0]  r_old;
  logic [1:0]       r_op;
  logic [4:0]       r_rd_adr;
  logic             r_read_en;
  logic             r_eff_wr;

  logic             w_idle;
  logic             w_trap_acc;
  logic             w_req_acc;
  logic             w_eff_wr;
  logic [XLEN-1:0]  w_src;
  logic [XLEN-1:0]  w_new;

  assign w_idle     = (r_state == StIdle);
  assign trap_ready = w_idle;
  assign req_ready  = w_idle & ~trap_valid;
  assign w_trap_acc = trap_valid & trap_ready;
  assign w_req_acc  = req_valid & req_ready;
  assign busy       = ~w_idle;
  assign rsp_rd_adr = r_rd_adr;

  // op==none never writes, even if the decoder asserted wr_en.
  assign w_eff_wr = req_wr_en & (req_op_ctr != OpNone);
  assign w_src    = req_imm_en ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_data;

  // A write that skipped the read is always op==write, so it reduces to src.
  always_comb begin
    w_new = r_src;
    case (r_op)
      OpSet:   w_new = r_old | r_src;
      OpClear: w_new = r_old & ~r_src;
      default: w_new = r_src;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_trap_acc) begin
          w_state_d = StTrapWr;
        end else if (w_req_acc) begin
          if (req_read_en | (w_eff_wr & (req_op_ctr != OpWrite))) begin
            w_state_d = StRead;
          end else if (w_eff_wr) begin
            w_state_d = StWrite;
          end else begin
            w_state_d = StResp;
          end
        end
      end
      StRead:   w_state_d = StWait;
      StWait:   w_state_d = r_eff_wr ? StWrite : StResp;
      StWrite:  w_state_d = StResp;
      StResp:   w_state_d = StIdle;
      StTrapWr: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = '0;
    ram_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_rd_we = 1'b0;
    case (r_state)
      StRead: begin
        ram_en  = 1'b1;
        ram_adr = r_adr;
      end
      StWrite: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_adr   = r_adr;
        ram_wdata = w_new;
      end
      StTrapWr: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_adr   = r_adr;
        ram_wdata = r_src;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_rd_we = r_read_en;
        rsp_rdata = r_read_en ? r_old : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_adr     <= '0;
      r_src     <= '0;
      r_old     <= '0;
      r_op      <= OpNone;
      r_rd_adr  <= '0;
      r_read_en <= 1'b0;
      r_eff_wr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_trap_acc) begin
        r_adr <= trap_adr;
        r_src <= trap_wdata;
      end else if (w_req_acc) begin
        r_adr     <= req_csr_adr;
        r_src     <= w_src;
        r_op      <= req_op_ctr;
        r_rd_adr  <= req_rd_adr;
        r_read_en <= req_read_en;
        r_eff_wr  <= w_eff_wr;
        r_old     <= '0;
      end
      if (r_state == StWait) begin
        r_old <= ram_rdata;
      end
    end
  end

endmodule
